// File: rtl/lamp_ctrl_nway.sv
// N-way lamp controller: synchronised, debounced switches where any single flip toggles the lamp.
// Switch-to-lamp latency DEBOUNCE_CYCLES+4 clocks; optional auto-off timer and forced-off request.
module lamp_ctrl_nway #(
   parameter int NUM_SW          = 3,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_OFF_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_SW-1:0] sw,
   input  logic              force_off,
   output logic              F,
   output logic [NUM_SW-1:0] sw_stable,
   output logic              toggle_evt
);
   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [23:0] AO_LAST = (AUTO_OFF_CYCLES == 0) ? 24'd0 : 24'(AUTO_OFF_CYCLES - 1);
   localparam bit          AO_EN   = (AUTO_OFF_CYCLES != 0);

   logic [NUM_SW-1:0] r_sync1;
   logic [NUM_SW-1:0] r_sync2;
   logic [NUM_SW-1:0] r_stable;
   logic [NUM_SW-1:0] r_stable_d;
   logic [NUM_SW-1:0] r_chg;
   logic [15:0]       r_db_cnt [NUM_SW];
   logic [23:0]       r_ao_cnt;
   logic              r_lamp;
   logic              r_evt;
   logic              w_chg_par;
   logic              w_chg_any;
   logic              w_timeout;

   // A level is accepted only after it has differed from the stable value for DEBOUNCE_CYCLES samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         for (int i = 0; i < NUM_SW; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1 <= sw;
         r_sync2 <= r_sync1;
         for (int i = 0; i < NUM_SW; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_stable[i] <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable_d <= '0;
         r_chg      <= '0;
      end else begin
         r_stable_d <= r_stable;
         r_chg      <= r_stable ^ r_stable_d;
      end
   end

   // Odd parity of the change vector means a net single flip; even counts cancel.
   assign w_chg_par = ^r_chg;
   assign w_chg_any = |r_chg;
   assign w_timeout = AO_EN && r_lamp && (r_ao_cnt == AO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lamp   <= 1'b0;
         r_evt    <= 1'b0;
         r_ao_cnt <= '0;
      end else begin
         r_evt <= 1'b0;
         if (force_off) begin
            r_lamp   <= 1'b0;
            r_ao_cnt <= '0;
         end else if (w_chg_par) begin
            r_lamp   <= ~r_lamp;
            r_evt    <= 1'b1;
            r_ao_cnt <= '0;
         end else if (w_timeout) begin
            r_lamp   <= 1'b0;
            r_ao_cnt <= '0;
         end else if (AO_EN && r_lamp && !w_chg_any) begin
            r_ao_cnt <= r_ao_cnt + 24'd1;
         end else begin
            r_ao_cnt <= '0;
         end
      end
   end

   assign F          = r_lamp;
   assign sw_stable  = r_stable;
   assign toggle_evt = r_evt;

endmodule

// File: tb/tb_lamp_ctrl_nway.sv
// Bench for lamp_ctrl_nway (NUM_SW=3, DEBOUNCE_CYCLES=4, AUTO_OFF_CYCLES=20).
// Expected lamp transitions are queued with their due cycle and matched as F changes.
module tb_lamp_ctrl_nway;
   localparam int NSW = 3;
   localparam int DEB = 4;
   localparam int AO  = 20;
   localparam int LAT = DEB + 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NSW-1:0] sw = '0;
   logic           force_off = 1'b0;
   logic           F;
   logic [NSW-1:0] sw_stable;
   logic           toggle_evt;

   typedef struct {
      int   cyc;
      logic f;
      logic evt;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   logic f_prev = 1'b0;

   lamp_ctrl_nway #(
      .NUM_SW(NSW), .DEBOUNCE_CYCLES(DEB), .AUTO_OFF_CYCLES(AO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .force_off(force_off),
      .F(F), .sw_stable(sw_stable), .toggle_evt(toggle_evt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Every F change or toggle pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (mon_en && (F !== f_prev || toggle_evt !== 1'b0)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d F=%b evt=%b, required no event", cyc, F, toggle_evt);
         end else begin
            e_mon = exp_q.pop_front();
            if (cyc != e_mon.cyc || F !== e_mon.f || toggle_evt !== e_mon.evt) begin
               errors++;
               $display("FAIL lamp_event got cyc=%0d F=%b evt=%b, required cyc=%0d F=%b evt=%b",
                        cyc, F, toggle_evt, e_mon.cyc, e_mon.f, e_mon.evt);
            end
         end
      end
      f_prev = F;
   end

   task automatic push_exp(input int c, input logic f, input logic ev);
      exp_t t;
      t.cyc = c; t.f = f; t.evt = ev;
      exp_q.push_back(t);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      mon_en = 1'b0;
      sw = '0;
      force_off = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      mon_en = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (F !== 1'b0) begin errors++; $display("FAIL reset_F got=%b exp=0", F); end
      checks++;
      if (sw_stable !== 3'b000) begin errors++; $display("FAIL reset_sw_stable got=%b exp=000", sw_stable); end
      checks++;
      if (toggle_evt !== 1'b0) begin errors++; $display("FAIL reset_toggle_evt got=%b exp=0", toggle_evt); end
      rst_n = 1'b1;
      mon_en = 1'b1;
      repeat (100) @(negedge clk);
      checks++;
      if (F !== 1'b0 || sw_stable !== 3'b000) begin
         errors++; $display("FAIL idle_state got F=%b sw_stable=%b exp F=0 sw_stable=000", F, sw_stable);
      end
   endtask

   task automatic test_single_toggle();
      int d;
      logic [NSW-1:0] pats [3];
      logic           lamp;
      pats[0] = 3'b100; pats[1] = 3'b110; pats[2] = 3'b111;
      do_reset();
      lamp = 1'b0;
      for (int k = 0; k < 3; k++) begin
         d = cyc;
         sw = pats[k];
         lamp = ~lamp;
         push_exp(d + LAT, lamp, 1'b1);
         if (k == 2) push_exp(d + LAT + AO, 1'b0, 1'b0);
         wait_until(d + LAT + 1);
         checks++;
         if (sw_stable !== pats[k] || F !== ^pats[k]) begin
            errors++;
            $display("FAIL single_toggle_%0d got sw_stable=%b F=%b exp sw_stable=%b F=%b",
                     k, sw_stable, F, pats[k], ^pats[k]);
         end
      end
      wait_until(d + LAT + AO + 2);
   endtask

   task automatic test_bounce();
      int d;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         sw = 3'b001;
         repeat (DEB - 1) @(negedge clk);
         sw = 3'b000;
         repeat (3) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (sw_stable !== 3'b000 || F !== 1'b0) begin
         errors++; $display("FAIL bounce_reject got sw_stable=%b F=%b exp 000 0", sw_stable, F);
      end
      d = cyc;
      sw = 3'b001;
      push_exp(d + LAT, 1'b1, 1'b1);
      push_exp(d + LAT + AO, 1'b0, 1'b0);
      wait_until(d + 10);
      checks++;
      if (sw_stable !== 3'b001) begin
         errors++; $display("FAIL bounce_accept got sw_stable=%b exp 001", sw_stable);
      end
      wait_until(d + LAT + AO + 2);
   endtask

   task automatic test_simultaneous();
      int d;
      do_reset();
      sw = 3'b011;
      repeat (LAT + 4) @(negedge clk);
      checks++;
      if (sw_stable !== 3'b011 || F !== 1'b0) begin
         errors++; $display("FAIL simultaneous got sw_stable=%b F=%b exp 011 0", sw_stable, F);
      end
      d = cyc;
      sw = 3'b111;
      push_exp(d + LAT, 1'b1, 1'b1);
      push_exp(d + LAT + AO, 1'b0, 1'b0);
      wait_until(d + LAT + AO + 2);
   endtask

   task automatic test_auto_off();
      int d;
      do_reset();
      d = cyc;
      sw = 3'b100;
      push_exp(d + LAT, 1'b1, 1'b1);
      push_exp(d + LAT + AO, 1'b0, 1'b0);
      wait_until(d + LAT + AO - 1);
      checks++;
      if (F !== 1'b1) begin errors++; $display("FAIL auto_off_early got F=%b exp 1", F); end
      wait_until(d + LAT + AO);
      checks++;
      if (F !== 1'b0 || toggle_evt !== 1'b0) begin
         errors++; $display("FAIL auto_off_fire got F=%b evt=%b exp 0 0", F, toggle_evt);
      end
      d = cyc;
      sw = 3'b000;
      push_exp(d + LAT, 1'b1, 1'b1);
      push_exp(d + LAT + AO, 1'b0, 1'b0);
      wait_until(d + LAT + AO + 2);
   endtask

   task automatic test_force_off();
      int d;
      int e;
      do_reset();
      d = cyc;
      sw = 3'b100;
      push_exp(d + LAT, 1'b1, 1'b1);
      wait_until(d + LAT + 1);
      e = cyc;
      sw = 3'b110;
      push_exp(e + LAT, 1'b0, 1'b0);
      wait_until(e + LAT - 1);
      force_off = 1'b1;
      wait_until(e + LAT);
      force_off = 1'b0;
      checks++;
      if (F !== 1'b0 || toggle_evt !== 1'b0) begin
         errors++; $display("FAIL force_off got F=%b evt=%b exp 0 0", F, toggle_evt);
      end
      wait_until(e + LAT + 30);
      checks++;
      if (sw_stable !== 3'b110 || F !== 1'b0) begin
         errors++; $display("FAIL force_off_after got sw_stable=%b F=%b exp 110 0", sw_stable, F);
      end
   endtask

   task automatic test_reset_mid();
      int d;
      int r;
      do_reset();
      d = cyc;
      sw = 3'b100;
      push_exp(d + LAT, 1'b1, 1'b1);
      wait_until(d + LAT + 1);
      sw = 3'b110;
      repeat (4) @(negedge clk);
      mon_en = 1'b0;
      checks++;
      if (F !== 1'b1 || sw_stable !== 3'b100) begin
         errors++; $display("FAIL pre_reset got F=%b sw_stable=%b exp 1 100", F, sw_stable);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (F !== 1'b0 || sw_stable !== 3'b000 || toggle_evt !== 1'b0) begin
         errors++; $display("FAIL async_reset got F=%b sw_stable=%b evt=%b exp 0 000 0", F, sw_stable, toggle_evt);
      end
      sw = 3'b010;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      r = cyc;
      exp_q.delete();
      mon_en = 1'b1;
      push_exp(r + LAT, 1'b1, 1'b1);
      push_exp(r + LAT + AO, 1'b0, 1'b0);
      wait_until(r + LAT + AO + 2);
      checks++;
      if (sw_stable !== 3'b010) begin
         errors++; $display("FAIL held_through_reset got sw_stable=%b exp 010", sw_stable);
      end
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending got %0d outstanding events exp 0", name, exp_q.size());
      end
   endtask

   initial begin
      test_reset();         check_drained("reset");
      test_single_toggle(); check_drained("single_toggle");
      test_bounce();        check_drained("bounce");
      test_simultaneous();  check_drained("simultaneous");
      test_auto_off();      check_drained("auto_off");
      test_force_off();     check_drained("force_off");
      test_reset_mid();     check_drained("reset_mid");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
